// File: rtl/stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_packer_if
// Brief    : Narrow-beat input stream and packed-word output stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_packer_if #(
    parameter int DW    = 8,
    parameter int RATIO = 4
);
    logic                  valid_i;
    logic                  ready_o;
    logic [DW-1:0]         data_i;
    logic                  last_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [DW*RATIO-1:0]   data_o;
    logic [RATIO-1:0]      strb_o;
    logic                  last_o;

    // Packer side of the link.
    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, strb_o, last_o
    );

    // Upstream source / downstream sink side of the link.
    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, strb_o, last_o
    );
endinterface
`default_nettype wire

// File: rtl/stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : stream_packer
// Brief    : Packs RATIO beats of DW bits into one word, flushing early on last.
// Revision : 1.0 - initial release
// ============================================================================
module stream_packer #(
    parameter int DW    = 8,
    parameter int RATIO = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    stream_packer_if.slave    bus
);
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] C_LAST_LANE = CW'(RATIO - 1);

    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic          r_last;

    logic          w_ready;
    logic          w_accept;
    logic          w_consume;
    logic          w_complete;

    // Output side is a single word register, so a beat may only land once
    // the held word is gone or leaving this cycle.
    assign w_ready    = rst_n && (!r_valid || bus.ready_i);
    assign w_accept   = bus.valid_i && w_ready;
    assign w_consume  = r_valid && bus.ready_i;
    assign w_complete = w_accept && ((r_cnt == C_LAST_LANE) || bus.last_i);

    assign bus.ready_o = w_ready;
    assign bus.valid_o = r_valid;
    assign bus.last_o  = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= w_complete ? '0 : r_cnt + 1'b1;
            end

            if (w_complete) begin
                r_valid <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end

            // A non-completing beat always carries last_i=0.
            if (w_accept) begin
                r_last <= bus.last_i;
            end else if (w_consume) begin
                r_last <= 1'b0;
            end
        end
    end

    // Each lane doubles as accumulator and output holding register; a consume
    // wipes every lane except the one the simultaneous new beat writes.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        logic [DW-1:0] r_lane;
        logic          r_fill;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lane <= '0;
                r_fill <= 1'b0;
            end else if (w_accept && (r_cnt == CW'(k))) begin
                r_lane <= bus.data_i;
                r_fill <= 1'b1;
            end else if (w_consume) begin
                r_lane <= '0;
                r_fill <= 1'b0;
            end
        end

        assign bus.data_o[k*DW +: DW] = r_lane;
        assign bus.strb_o[k]          = r_fill;
    end
endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_packer
// Brief    : Directed self-checking bench for stream_packer (DW=8, RATIO=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_packer;
    localparam int DW    = 8;
    localparam int RATIO = 4;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } word_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    stream_packer_if #(.DW(DW), .RATIO(RATIO)) ifc ();

    stream_packer #(.DW(DW), .RATIO(RATIO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
        end
    endtask

    // Reference: words pending on the output, beats gathered so far, and a
    // log of every word actually consumed downstream.
    word_t       mq[$];
    word_t       wlog[$];
    logic [31:0] cur_data = '0;
    int          nbeats   = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            cur_data = '0;
            nbeats   = 0;
            chk("rst_valid_o", 32'(ifc.valid_o), 32'd0);
            chk("rst_ready_o", 32'(ifc.ready_o), 32'd0);
            chk("rst_data_o",  ifc.data_o,       32'd0);
            chk("rst_strb_o",  32'(ifc.strb_o),  32'd0);
        end else begin
            logic  exp_ready;
            word_t w;
            exp_ready = (mq.size() == 0) || ifc.ready_i;
            chk("ready_o", 32'(ifc.ready_o), 32'(exp_ready));
            if (mq.size() > 0) begin
                chk("valid_o", 32'(ifc.valid_o), 32'd1);
                chk("data_o",  ifc.data_o,       mq[0].d);
                chk("strb_o",  32'(ifc.strb_o),  32'(mq[0].s));
                chk("last_o",  32'(ifc.last_o),  32'(mq[0].l));
                if (ifc.ready_i) begin
                    w.d = ifc.data_o; w.s = ifc.strb_o; w.l = ifc.last_o;
                    wlog.push_back(w);
                    void'(mq.pop_front());
                end
            end else begin
                chk("valid_o_idle", 32'(ifc.valid_o), 32'd0);
            end
            if (ifc.valid_i && exp_ready) begin
                cur_data = cur_data | (32'(ifc.data_i) << (8 * nbeats));
                nbeats++;
                if (nbeats == RATIO || ifc.last_i) begin
                    w.d = cur_data;
                    w.s = 4'((1 << nbeats) - 1);
                    w.l = ifc.last_i;
                    mq.push_back(w);
                    cur_data = '0;
                    nbeats   = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l, output int waits);
        logic acc;
        ifc.valid_i = 1'b1;
        ifc.data_i  = d;
        ifc.last_i  = l;
        waits       = 0;
        forever begin
            @(negedge clk);
            acc = ifc.ready_o;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout got=stalled exp=accepted @%0t", $time);
                break;
            end
        end
        ifc.valid_i = 1'b0;
        ifc.last_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string nm, input int idx, input logic [31:0] d,
                            input logic [3:0] s, input logic l);
        checks++;
        if (idx >= wlog.size()) begin
            failures++;
            $display("FAIL %s_present got=%0d words exp>%0d", nm, wlog.size(), idx);
        end else begin
            checks--;
            chk({nm, "_data"}, wlog[idx].d, d);
            chk({nm, "_strb"}, 32'(wlog[idx].s), 32'(s));
            chk({nm, "_last"}, 32'(wlog[idx].l), 32'(l));
        end
    endtask

    initial begin
        int w;
        int wsum;
        logic [7:0] seq [4];
        ifc.valid_i = 1'b0;
        ifc.data_i  = '0;
        ifc.last_i  = 1'b0;
        ifc.ready_i = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Four full beats.
        wlog.delete();
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) send(seq[i], 1'b0, w);
        chk("full_valid_next", 32'(ifc.valid_o), 32'd1);
        chk("full_data_next", ifc.data_o, 32'h44332211);
        idle(3);
        chk("full_count", 32'(wlog.size()), 32'd1);
        chk_word("full", 0, 32'h44332211, 4'hF, 1'b0);

        // Short packet flushed by last.
        wlog.delete();
        send(8'hAA, 1'b0, w);
        send(8'hBB, 1'b1, w);
        idle(3);
        chk_word("short", 0, 32'h0000BBAA, 4'h3, 1'b1);

        // Continuous stream of eight beats.
        wlog.delete();
        wsum = 0;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b0, w);
            wsum += w;
        end
        chk("stream_no_stall", 32'(wsum), 32'd0);
        idle(3);
        chk_word("stream0", 0, 32'h04030201, 4'hF, 1'b0);
        chk_word("stream1", 1, 32'h08070605, 4'hF, 1'b0);

        // Backpressure for five cycles with a beat waiting.
        wlog.delete();
        ifc.ready_i = 1'b0;
        seq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        for (int i = 0; i < 4; i++) send(seq[i], 1'b0, w);
        ifc.valid_i = 1'b1;
        ifc.data_i  = 8'hE1;
        ifc.last_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(ifc.valid_o), 32'd1);
            chk("stall_ready", 32'(ifc.ready_o), 32'd0);
            chk("stall_data",  ifc.data_o, 32'hC4C3C2C1);
        end
        @(posedge clk);
        #1;
        ifc.ready_i = 1'b1;
        send(8'hE1, 1'b1, w);
        chk("stall_same_cycle", 32'(w), 32'd0);
        chk("stall_new_strb", 32'(ifc.strb_o), 32'h1);
        chk("stall_new_data", ifc.data_o, 32'h000000E1);
        idle(3);
        chk_word("stall0", 0, 32'hC4C3C2C1, 4'hF, 1'b0);
        chk_word("stall1", 1, 32'h000000E1, 4'h1, 1'b1);

        // Reset in the middle of a word.
        wlog.delete();
        send(8'hDE, 1'b0, w);
        send(8'hAD, 1'b0, w);
        chk("pre_rst_data", ifc.data_o, 32'h0000ADDE);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data",  ifc.data_o, 32'd0);
        chk("mid_rst_strb",  32'(ifc.strb_o), 32'd0);
        chk("mid_rst_ready", 32'(ifc.ready_o), 32'd0);
        chk("mid_rst_valid", 32'(ifc.valid_o), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("rst_no_orphan", 32'(wlog.size()), 32'd0);
        seq = '{8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 4; i++) send(seq[i], 1'b0, w);
        idle(3);
        chk_word("after_rst", 0, 32'h88776655, 4'hF, 1'b0);

        // Lone last beat with idle gaps, then a gapped full word.
        wlog.delete();
        idle(3);
        send(8'h9C, 1'b1, w);
        idle(3);
        seq = '{8'h10, 8'h20, 8'h30, 8'h40};
        for (int i = 0; i < 4; i++) begin
            send(seq[i], 1'b0, w);
            idle(i + 1);
        end
        idle(2);
        chk_word("single", 0, 32'h0000009C, 4'h1, 1'b1);
        chk_word("gapped", 1, 32'h40302010, 4'hF, 1'b0);

        // Last on the fourth lane still reports last.
        wlog.delete();
        seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 4; i++) send(seq[i], i == 3, w);
        idle(3);
        chk_word("last_lane3", 0, 32'hA4A3A2A1, 4'hF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
